// File: rtl/multiply_tokens.sv
// Token multiplier: each high cycle of `a` owes FACTOR single-cycle pulses on `b`,
// issued at most one per clock from a saturating pending counter with sticky overflow.
module multiply_tokens #(
    parameter int FACTOR      = 2,
    parameter int MAX_PENDING = 255,
    localparam int CNT_W      = $clog2(MAX_PENDING + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             a,
    output logic             b,
    output logic [CNT_W-1:0] pending,
    output logic             overflow,
    output logic             idle
);

    // One spare bit so pending + FACTOR never wraps before the saturation test.
    localparam int EW = CNT_W + 1;
    localparam logic [EW-1:0]    FACTOR_W = EW'(FACTOR);
    localparam logic [EW-1:0]    MAX_W    = EW'(MAX_PENDING);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_PENDING);

    logic [EW-1:0] add;
    logic [EW-1:0] eff;
    logic [EW-1:0] nxt;
    logic          issue;

    always_comb begin
        add   = a ? FACTOR_W : '0;
        eff   = {1'b0, pending} + add;
        issue = (eff != '0);
        nxt   = eff - {{CNT_W{1'b0}}, issue};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b        <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            b        <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            b <= issue;
            if (nxt > MAX_W) begin
                pending  <= MAX_C;
                overflow <= 1'b1;
            end else begin
                pending  <= nxt[CNT_W-1:0];
            end
        end
    end

    assign idle = (pending == '0) && !b;

endmodule

// File: tb/tb_multiply_tokens.sv
// Bench for multiply_tokens: three configurations share one stimulus stream and are
// compared every cycle against an integer token-accounting model.
module tb_multiply_tokens;

    logic clk;
    logic rst;
    logic clear;
    logic a;

    logic       b0, ov0, idle0;
    logic [7:0] pend0;
    logic       b1, ov1, idle1;
    logic [3:0] pend1;
    logic       b2, ov2, idle2;
    logic [2:0] pend2;

    multiply_tokens #(.FACTOR(2), .MAX_PENDING(255)) u_dut (
        .clk(clk), .rst(rst), .clear(clear), .a(a),
        .b(b0), .pending(pend0), .overflow(ov0), .idle(idle0)
    );

    multiply_tokens #(.FACTOR(2), .MAX_PENDING(15)) u_sat (
        .clk(clk), .rst(rst), .clear(clear), .a(a),
        .b(b1), .pending(pend1), .overflow(ov1), .idle(idle1)
    );

    multiply_tokens #(.FACTOR(1), .MAX_PENDING(7)) u_one (
        .clk(clk), .rst(rst), .clear(clear), .a(a),
        .b(b2), .pending(pend2), .overflow(ov2), .idle(idle2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // reference model: tokens owed per instance
    localparam int FAC  [3] = '{2, 2, 1};
    localparam int MAXP [3] = '{255, 15, 7};
    int   m_owed [3];
    logic m_b    [3];
    logic m_ovf  [3];

    int n_checks = 0;
    int n_errors = 0;
    int a_count  = 0;
    int b_count  = 0;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_owed[i] = 0;
            m_b[i]    = 1'b0;
            m_ovf[i]  = 1'b0;
        end
    endtask

    task automatic model_edge(input logic av, input logic cv);
        int owed;
        for (int i = 0; i < 3; i++) begin
            if (cv) begin
                m_owed[i] = 0;
                m_b[i]    = 1'b0;
                m_ovf[i]  = 1'b0;
            end else begin
                owed   = m_owed[i] + (av ? FAC[i] : 0);
                m_b[i] = (owed > 0);
                if (owed > 0) owed = owed - 1;
                if (owed > MAXP[i]) begin
                    m_owed[i] = MAXP[i];
                    m_ovf[i]  = 1'b1;
                end else begin
                    m_owed[i] = owed;
                end
            end
        end
    endtask

    function automatic logic [31:0] get_b(int i);
        case (i)
            0:       return {31'd0, b0};
            1:       return {31'd0, b1};
            default: return {31'd0, b2};
        endcase
    endfunction

    function automatic logic [31:0] get_pend(int i);
        case (i)
            0:       return {24'd0, pend0};
            1:       return {28'd0, pend1};
            default: return {29'd0, pend2};
        endcase
    endfunction

    function automatic logic [31:0] get_ovf(int i);
        case (i)
            0:       return {31'd0, ov0};
            1:       return {31'd0, ov1};
            default: return {31'd0, ov2};
        endcase
    endfunction

    function automatic logic [31:0] get_idle(int i);
        case (i)
            0:       return {31'd0, idle0};
            1:       return {31'd0, idle1};
            default: return {31'd0, idle2};
        endcase
    endfunction

    // scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d.b", i),        get_b(i),    {31'd0, m_b[i]});
            check($sformatf("u%0d.pending", i),  get_pend(i), m_owed[i]);
            check($sformatf("u%0d.overflow", i), get_ovf(i),  {31'd0, m_ovf[i]});
            check($sformatf("u%0d.idle", i),     get_idle(i),
                  {31'd0, (m_owed[i] == 0) && !m_b[i]});
        end
    endtask

    // driver: inputs change at the falling edge, outputs sampled 1ns after the rising edge
    task automatic step(input logic av, input logic cv);
        @(negedge clk);
        a     = av;
        clear = cv;
        @(posedge clk);
        if (rst) model_edge(av, cv);
        #1;
        if (rst && !cv && av) a_count++;
        if (b0 === 1'b1) b_count++;
        check_all();
    endtask

    initial begin
        rst   = 1'b0;
        clear = 1'b0;
        a     = 1'b0;
        model_reset();

        // reset held for two edges with a toggling
        #1;
        check_all();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("rst_idle", {31'd0, idle0}, 32'd1);

        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0);
        check("post_rst_idle", {31'd0, idle0}, 32'd1);

        // single token
        step(1'b1, 1'b0);
        check("single_b_1", {31'd0, b0}, 32'd1);
        check("single_p_1", {24'd0, pend0}, 32'd1);
        step(1'b0, 1'b0);
        check("single_b_2", {31'd0, b0}, 32'd1);
        check("single_p_2", {24'd0, pend0}, 32'd0);
        step(1'b0, 1'b0);
        check("single_b_3", {31'd0, b0}, 32'd0);
        check("single_idle", {31'd0, idle0}, 32'd1);

        // random stream, then drain
        a_count = 0;
        b_count = 0;
        for (int k = 0; k < 100; k++) step(1'($urandom_range(0, 1)), 1'b0);
        for (int k = 0; k < 300; k++) step(1'b0, 1'b0);
        check("rand_b_count", b_count, 2 * a_count);
        check("rand_ovf", {31'd0, ov0}, 32'd0);
        check("rand_pend", {24'd0, pend0}, 32'd0);

        // saturation of the MAX_PENDING=15 instance
        step(1'b0, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, 1'b0);
            check("sat_b", {31'd0, b1}, 32'd1);
            check("sat_pend", {28'd0, pend1}, (k < 15) ? k : 15);
            check("sat_ovf", {31'd0, ov1}, (k >= 16) ? 32'd1 : 32'd0);
            check("f1_b", {31'd0, b2}, 32'd1);
            check("f1_pend", {29'd0, pend2}, 32'd0);
        end
        for (int k = 0; k < 40; k++) step(1'b0, 1'b0);
        check("sat_drained", {28'd0, pend1}, 32'd0);
        check("sat_ovf_sticky", {31'd0, ov1}, 32'd1);

        // clear beats a
        for (int k = 0; k < 7; k++) step(1'b1, 1'b0);
        check("pre_clear_pend", {28'd0, pend1}, 32'd7);
        check("pre_clear_ovf", {31'd0, ov1}, 32'd1);
        step(1'b1, 1'b1);
        check("clear_pend", {28'd0, pend1}, 32'd0);
        check("clear_ovf", {31'd0, ov1}, 32'd0);
        check("clear_b", {31'd0, b1}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0);
            check("clear_no_emit", {31'd0, b1}, 32'd0);
        end

        // asynchronous reset in the middle of a 6-token burst
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("burst_pend", {24'd0, pend0}, 32'd2);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("arst_b", {31'd0, b0}, 32'd0);
        check("arst_pend", {24'd0, pend0}, 32'd0);
        check_all();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0);
            check("arst_quiet", {31'd0, b0}, 32'd0);
        end
        step(1'b1, 1'b0);
        check("arst_resume", {31'd0, b0}, 32'd1);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
